// File: rtl/sseg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
//   arb_state_t : arbiter FSM states (IDLE, OWN)
//   DIGITS      : digits per display word
//   DIGIT_W     : bits per hex digit
//   WORD_W      : bits per display word
//   disp_word_t : one packed display word, digit 0 in the low nibble
package sseg_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned WORD_W  = DIGITS * DIGIT_W;

  typedef logic [WORD_W-1:0] disp_word_t;

endpackage

// File: rtl/sseg_disp_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Finds the first request that is set and not excluded, searching upward
// from ptr and wrapping around modulo N.
//   req   : request lines
//   ptr   : search start index (must be < N)
//   excl  : requests to ignore (e.g. the current owner)
//   found : some eligible request exists
//   idx   : index of the picked request (0 when nothing found)
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  input  logic [N-1:0]     excl,
  output logic             found,
  output logic [PTR_W-1:0] idx
);

  logic [N-1:0]   cand;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int unsigned    pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    cand  = req & ~excl;
    // Rotating right by ptr puts the search start at bit 0, so the
    // lowest set bit of rot is the round-robin winner.
    dbl   = {cand, cand} >> ptr;
    rot   = dbl[N-1:0];
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        pos   = (int'(ptr) + k) % N;
        idx   = PTR_W'(pos);
      end
    end
  end

endmodule

// File: rtl/sseg_disp_arbiter.sv
// Round-robin arbiter sharing one 4-digit seven-segment display between
// NUM_REQ requesters, with a minimum-hold timer so ownership cannot thrash.
// An owner that drops its request is released immediately; a competing
// request only wins once the owner has held the display for HOLD_TICKS ticks.
//
// Ports:
//   clk        : system clock
//   reset      : synchronous, active-high reset
//   req        : level-sensitive request lines, one per requester
//   data       : packed display words, requester i uses data[16i+15:16i]
//   grant      : registered one-hot grant (zero when idle)
//   owner      : index of current owner, valid while busy
//   busy       : a grant is active
//   switch_p   : one-cycle pulse on every new grant
//   hex0..hex3 : registered digits to the display mux
//
// Build option: define SSEG_OWNER_TAG_EN to show the owner index on hex3
// instead of digit 3 of the owner's word.
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; arbitrate among requests from the RR pointer
// OWN   | one requester owns the display; hex tracks its word, hold runs
module sseg_disp_arbiter
  import sseg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TICK_FINAL = 99999,
  parameter int unsigned HOLD_TICKS = 1000,
  parameter int unsigned TICK_WIDTH = 17,
  parameter int unsigned HOLD_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [WORD_W*NUM_REQ-1:0]   data,
  output logic [NUM_REQ-1:0]          grant,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic                        busy,
  output logic                        switch_p,
  output logic [DIGIT_W-1:0]          hex0,
  output logic [DIGIT_W-1:0]          hex1,
  output logic [DIGIT_W-1:0]          hex2,
  output logic [DIGIT_W-1:0]          hex3
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  arb_state_t             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic                   switch_q, switch_d;
  logic [TICK_WIDTH-1:0]  presc_q, presc_d;
  logic [HOLD_WIDTH-1:0]  hold_q, hold_d;
  disp_word_t             hex_q, hex_d;

  logic                   pick_found;
  logic [PTR_W-1:0]       pick_idx;
  disp_word_t             owner_word;
  logic                   owner_req;
  logic                   tick;
  logic                   hold_exp;
  logic                   take;

  // grant_q is zero in IDLE and the owner's one-hot in OWN, so it doubles
  // as the exclusion mask for both uses of the picker.
  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .excl  (grant_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_word = data[WORD_W*int'(owner_q) +: WORD_W];
  assign owner_req  = |(req & grant_q);
  assign tick       = (presc_q == TICK_WIDTH'(TICK_FINAL));
  assign hold_exp   = (hold_q == HOLD_WIDTH'(HOLD_TICKS));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    switch_d = 1'b0;
    presc_d  = presc_q;
    hold_d   = hold_q;
    hex_d    = hex_q;
    take     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          take = 1'b1;
        end
      end
      OWN: begin
        for (int d = 0; d < DIGITS; d++) begin
          hex_d[d*DIGIT_W +: DIGIT_W] = owner_word[d*DIGIT_W +: DIGIT_W];
        end
`ifdef SSEG_OWNER_TAG_EN
        hex_d[(DIGITS-1)*DIGIT_W +: DIGIT_W] = DIGIT_W'(owner_q);
`endif
        if (tick) begin
          presc_d = '0;
          if (!hold_exp) begin
            hold_d = hold_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end

        // Owner release beats hold expiry, so a drop on the expiry cycle
        // produces a single switch.
        if (!owner_req) begin
          if (pick_found) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            presc_d = '0;
            hold_d  = '0;
          end
        end else if (hold_exp && pick_found) begin
          take = 1'b1;
        end
      end
    endcase

    if (take) begin
      state_d  = OWN;
      grant_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
      owner_d  = pick_idx;
      switch_d = 1'b1;
      ptr_d    = (pick_idx == PTR_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
      presc_d  = '0;
      hold_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      switch_q <= 1'b0;
      presc_q  <= '0;
      hold_q   <= '0;
      hex_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      switch_q <= switch_d;
      presc_q  <= presc_d;
      hold_q   <= hold_d;
      hex_q    <= hex_d;
    end
  end

  assign grant    = grant_q;
  assign owner    = owner_q;
  assign busy     = |grant_q;
  assign switch_p = switch_q;
  assign hex0     = hex_q[0*DIGIT_W +: DIGIT_W];
  assign hex1     = hex_q[1*DIGIT_W +: DIGIT_W];
  assign hex2     = hex_q[2*DIGIT_W +: DIGIT_W];
  assign hex3     = hex_q[3*DIGIT_W +: DIGIT_W];

endmodule
